// File: rtl/mod60_tens_stage.sv
// Tens-digit stage of a mod-60 seconds counter, clocked on the falling edge to match the ones stage.
// Define SEG_SCAN_EN to multiplex both digits onto a 2-digit active-low 7-segment display.
module mod60_tens_stage #(
  parameter int TENS_MAX    = 5,
  parameter int REFRESH_DIV = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic [3:0] ones_in,
  input  logic       enable,
  input  logic       load_req,
  input  logic [3:0] load_val,
  output logic       load_ack,
  output logic [3:0] tens,
  output logic       carry,
  output logic       err,
  output logic [6:0] seg_n,
  output logic [1:0] an_n
);

  if (REFRESH_DIV < 2) begin : g_div_check
    $error("REFRESH_DIV must be at least 2");
  end

  typedef enum logic {HS_IDLE, HS_ACK} hs_e;

  localparam logic [3:0] TENS_LAST = 4'(TENS_MAX);

  hs_e        hs_q;
  logic [3:0] tens_q;
  logic       carry_q;
  logic       ack_q;
  logic       err_q;

  logic valid_tick;
  logic load_accept;

  // The ones stage holds 9 for exactly the cycle it raises tick_in; anything else is a fault.
  assign valid_tick  = tick_in && (ones_in == 4'd9);
  assign load_accept = (hs_q == HS_IDLE) && load_req;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      hs_q    <= HS_IDLE;
      tens_q  <= 4'd0;
      carry_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      carry_q <= 1'b0;
      if (tick_in && !valid_tick) err_q <= 1'b1;

      unique case (hs_q)
        HS_IDLE: begin
          if (load_req) begin
            hs_q  <= HS_ACK;
            ack_q <= 1'b1;
            if (load_val <= TENS_LAST) tens_q <= load_val;
            else                       err_q  <= 1'b1;
          end
        end
        HS_ACK: begin
          ack_q <= 1'b0;
          if (!load_req) hs_q <= HS_IDLE;
        end
        default: hs_q <= HS_IDLE;
      endcase

      // A load accepted on this edge takes priority and the coincident tick is lost.
      if (enable && valid_tick && !load_accept) begin
        if (tens_q == TENS_LAST) begin
          tens_q  <= 4'd0;
          carry_q <= 1'b1;
        end else begin
          tens_q  <= tens_q + 4'd1;
        end
      end
    end
  end

  assign tens     = tens_q;
  assign carry    = carry_q;
  assign load_ack = ack_q;
  assign err      = err_q;

`ifdef SEG_SCAN_EN
  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] refresh_q;
  logic             sel_q;
  logic [6:0]       seg_q;
  logic [1:0]       an_q;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    s = 7'h7F;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // sel_q == 0 selects ones; outputs are registered, so each slot shows one cycle after selection.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      refresh_q <= '0;
      sel_q     <= 1'b0;
      seg_q     <= 7'h7F;
      an_q      <= 2'b11;
    end else begin
      if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
        refresh_q <= '0;
        sel_q     <= ~sel_q;
      end else begin
        refresh_q <= refresh_q + CNT_W'(1);
      end
      an_q  <= sel_q ? 2'b01 : 2'b10;
      seg_q <= seg_decode(sel_q ? tens_q : ones_in);
    end
  end

  assign seg_n = seg_q;
  assign an_n  = an_q;
`else
  assign seg_n = 7'h7F;
  assign an_n  = 2'b11;
`endif

endmodule

// File: tb/tb_mod60_tens_stage.sv
// Self-checking bench for mod60_tens_stage: reset, vector table, directed corner sequences and a
// randomized run against a behavioural model of the counter and load handshake.
module tb_mod60_tens_stage;

  localparam int TM = 5;
  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_in = 1'b0;
  logic [3:0] ones_in = 4'd0;
  logic       enable = 1'b0;
  logic       load_req = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       load_ack;
  logic [3:0] tens;
  logic       carry;
  logic       err;
  logic [6:0] seg_n;
  logic [1:0] an_n;

  mod60_tens_stage #(.TENS_MAX(TM), .REFRESH_DIV(RD)) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .ones_in(ones_in), .enable(enable),
    .load_req(load_req), .load_val(load_val), .load_ack(load_ack), .tens(tens),
    .carry(carry), .err(err), .seg_n(seg_n), .an_n(an_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the tens digit is a number modulo TM+1, and a load is granted once per
  // rising request (the requester must drop load_req before another grant).
  int m_tens;
  bit m_carry, m_ack, m_err, m_waiting_drop;

  task automatic model_reset();
    m_tens = 0; m_carry = 0; m_ack = 0; m_err = 0; m_waiting_drop = 0;
  endtask

  task automatic model_step(input bit t, input int o, input bit e, input bit r, input int v);
    bit grant;
    grant   = r && !m_waiting_drop;
    m_carry = 0;
    m_ack   = grant;
    if (t && o != 9) m_err = 1;
    if (grant) begin
      if (v <= TM) m_tens = v;
      else         m_err  = 1;
      m_waiting_drop = 1;
    end else begin
      if (!r) m_waiting_drop = 0;
      if (e && t && o == 9) begin
        m_tens  = (m_tens + 1) % (TM + 1);
        m_carry = (m_tens == 0);
      end
    end
  endtask

  // Called at a posedge; drives inputs, lets the DUT take its falling edge, returns at next posedge.
  task automatic apply(input bit t, input int o, input bit e, input bit r, input int v);
    tick_in = t; ones_in = 4'(o); enable = e; load_req = r; load_val = 4'(v);
    @(negedge clk);
    model_step(t, o, e, r, v);
    @(posedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, " tens"}, 32'(tens), 32'(m_tens));
    check({tag, " carry"}, 32'(carry), 32'(m_carry));
    check({tag, " load_ack"}, 32'(load_ack), 32'(m_ack));
    check({tag, " err"}, 32'(err), 32'(m_err));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    tick_in = 0; enable = 0; load_req = 0; load_val = 0;
    repeat (2) @(posedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return (d >= 0 && d <= 9) ? tbl[d] : 7'h7F;
  endfunction

  typedef struct {
    bit       tick;
    bit [3:0] ones;
    bit       en;
    bit       req;
    bit [3:0] val;
    bit [3:0] e_tens;
    bit       e_carry;
    bit       e_ack;
    bit       e_err;
  } vec_t;

  vec_t vecs [18];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int carries;
    bit r;

    vecs[0]  = '{0, 0, 1, 1, 4, 4, 0, 1, 0};
    vecs[1]  = '{0, 0, 1, 1, 4, 4, 0, 0, 0};
    vecs[2]  = '{0, 0, 1, 1, 4, 4, 0, 0, 0};
    vecs[3]  = '{0, 0, 1, 1, 4, 4, 0, 0, 0};
    vecs[4]  = '{0, 0, 1, 1, 4, 4, 0, 0, 0};
    vecs[5]  = '{0, 0, 1, 0, 0, 4, 0, 0, 0};
    vecs[6]  = '{0, 0, 1, 1, 5, 5, 0, 1, 0};
    vecs[7]  = '{0, 0, 1, 0, 0, 5, 0, 0, 0};
    vecs[8]  = '{1, 9, 1, 1, 2, 2, 0, 1, 0};
    vecs[9]  = '{1, 9, 1, 0, 0, 3, 0, 0, 0};
    vecs[10] = '{1, 9, 0, 0, 0, 3, 0, 0, 0};
    vecs[11] = '{1, 9, 0, 0, 0, 3, 0, 0, 0};
    vecs[12] = '{1, 9, 1, 0, 0, 4, 0, 0, 0};
    vecs[13] = '{1, 9, 1, 0, 0, 5, 0, 0, 0};
    vecs[14] = '{1, 9, 1, 0, 0, 0, 1, 0, 0};
    vecs[15] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[16] = '{0, 0, 1, 1, 7, 0, 0, 1, 1};
    vecs[17] = '{0, 0, 1, 0, 0, 0, 0, 0, 1};

    // Power-on reset state
    #1;
    check("rst tens", 32'(tens), 32'd0);
    check("rst carry", 32'(carry), 32'd0);
    check("rst load_ack", 32'(load_ack), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst seg_n", 32'(seg_n), 32'h7F);
    check("rst an_n", 32'(an_n), 32'h3);
    @(posedge clk);
    reset = 1'b1;
    model_reset();

    // Vector table: loads, held request, load vs tick, enable gating, wrap, rejected load
    for (int i = 0; i < 18; i++) begin
      apply(vecs[i].tick, vecs[i].ones, vecs[i].en, vecs[i].req, vecs[i].val);
      check($sformatf("vec%0d tens", i), 32'(tens), 32'(vecs[i].e_tens));
      check($sformatf("vec%0d carry", i), 32'(carry), 32'(vecs[i].e_carry));
      check($sformatf("vec%0d load_ack", i), 32'(load_ack), 32'(vecs[i].e_ack));
      check($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].e_err));
    end

    // One full minute driven by a modelled ones digit
    do_reset();
    carries = 0;
    for (int s = 0; s < 60; s++) begin
      apply((s % 10) == 9, s % 10, 1, 0, 0);
      check($sformatf("minute s%0d tens", s), 32'(tens), 32'(((s + 1) / 10) % 6));
      if (carry) carries++;
    end
    check("minute carry at 60th", 32'(carry), 32'd1);
    check("minute carry count", 32'(carries), 32'd1);
    apply(0, 0, 1, 0, 0);
    check("minute carry width", 32'(carry), 32'd0);

    // Bad tick sets sticky err; out-of-range ones without tick is ignored
    do_reset();
    apply(0, 12, 1, 0, 0);
    check("no-tick ones=12 err", 32'(err), 32'd0);
    apply(1, 4, 1, 0, 0);
    check("bad tick err", 32'(err), 32'd1);
    check("bad tick tens", 32'(tens), 32'd0);
    apply(1, 9, 1, 0, 0);
    apply(1, 9, 1, 0, 0);
    check("err sticky", 32'(err), 32'd1);
    check("valid ticks after err", 32'(tens), 32'd2);

    // Async reset mid-operation with tens=3, ack high and a pending handshake
    apply(0, 0, 1, 1, 3);
    check("pre-reset tens", 32'(tens), 32'd3);
    check("pre-reset ack", 32'(load_ack), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async rst tens", 32'(tens), 32'd0);
    check("async rst carry", 32'(carry), 32'd0);
    check("async rst err", 32'(err), 32'd0);
    check("async rst load_ack", 32'(load_ack), 32'd0);
    @(posedge clk);
    reset = 1'b1;
    model_reset();
    apply(0, 0, 1, 1, 1);
    check("handshake abandoned ack", 32'(load_ack), 32'd1);
    check("handshake abandoned tens", 32'(tens), 32'd1);
    apply(0, 0, 1, 0, 0);

    // Display scan, ones=7 and tens loaded to 3 on the first edge
    ones_in = 4'd7;
    @(posedge clk);
    #2 reset = 1'b0;
    tick_in = 0; load_req = 0;
    repeat (2) @(posedge clk);
    reset = 1'b1;
    model_reset();
    check("scan post-rst an_n", 32'(an_n), 32'h3);
    check("scan post-rst seg_n", 32'(seg_n), 32'h7F);
    for (int e = 1; e <= 16; e++) begin
      apply(0, 7, 0, e == 1, 3);
`ifdef SEG_SCAN_EN
      if (((e - 1) / RD) % 2 == 0) begin
        check($sformatf("scan e%0d an_n", e), 32'(an_n), 32'h2);
        check($sformatf("scan e%0d seg_n", e), 32'(seg_n), 32'(seg_of(7)));
      end else begin
        check($sformatf("scan e%0d an_n", e), 32'(an_n), 32'h1);
        check($sformatf("scan e%0d seg_n", e), 32'(seg_n), 32'(seg_of(3)));
      end
`else
      check($sformatf("dark e%0d an_n", e), 32'(an_n), 32'h3);
      check($sformatf("dark e%0d seg_n", e), 32'(seg_n), 32'h7F);
`endif
    end
    check("scan tens loaded", 32'(tens), 32'd3);

    // Randomized run against the model
    do_reset();
    r = 0;
    for (int i = 0; i < 3000; i++) begin
      bit t, e;
      int o, v;
      t = ($urandom % 3) == 0;
      if (t) begin
        o = 9;
        if ($urandom % 64 == 0) begin
          o = int'($urandom % 16);
          if (o == 9) o = 3;
        end
      end else begin
        o = int'($urandom % 16);
      end
      e = ($urandom % 4) != 0;
      if ($urandom % 4 == 0) r = ~r;
      v = int'($urandom % 8);
      apply(t, o, e, r, v);
      check_model($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
